conv_bank_loader: RTL and testbench
===================================

Name: conv_bank_loader

Overview:
- Sequencer that drives the load side of the convolution parameter bank.
- Accepts a layer-load command, then pulls 32-bit words from an upstream valid/ready stream (parameter memory reader / DMA).
- Emits words in fixed order: M0 (2 words), CN (1 word), K (runtime-selected word count), each with the matching one-hot load enable.
- Sits between the parameter fetch path and the bank's i_enb_M0 / i_enb_CN / i_enb_K / i_data inputs.

Parameters:
- WORD_WIDTH, 32, stream and bank data width.
- M0_WORDS, 2, words per M0 load.
- K_WORDS_MAX, 3, max kernel words (ceil(9 bytes / 4)).
- KW_WIDTH, 2, width of i_k_words (must hold K_WORDS_MAX).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_start  input  1  load command, one-cycle pulse, sampled only in IDLE
- i_k_words  input  KW_WIDTH  kernel word count for this load, sampled with i_start
- i_flush  input  1  synchronous abort, returns to IDLE
- i_s_valid  input  1  upstream word valid
- i_s_data  input  WORD_WIDTH  upstream word
- o_s_ready  output  1  loader can accept a word
- o_enb_M0  output  1  bank M0 shift enable
- o_enb_CN  output  1  bank CN load enable
- o_enb_K  output  1  bank K shift enable
- o_data  output  WORD_WIDTH  word to bank
- o_busy  output  1  load in progress (state != IDLE)
- o_done  output  1  one-cycle pulse, load complete

Behaviour:
- Reset (async, rst_n=0): state IDLE, counters 0, latched k_words 0. All outputs 0 (o_s_ready, o_enb_*, o_data, o_busy, o_done).
- States: IDLE, LD_M0, LD_CN, LD_K.
- IDLE: o_s_ready=0. If i_start=1, latch kw = min(i_k_words, K_WORDS_MAX), clear word counter, go to LD_M0 next cycle. i_start outside IDLE is ignored.
- Load states: o_s_ready=1 (combinational from state). Beat = i_s_valid & o_s_ready. No beat: hold state and counter.
- LD_M0: each beat increments counter. On beat M0_WORDS, clear counter and go to LD_CN.
- LD_CN: one beat. Then go to LD_K if kw>0, else IDLE.
- LD_K: on beat kw, go to IDLE.
- Output timing (registered, latency 1): beat accepted in cycle T gives o_data=word and exactly one o_enb_x=1 in cycle T+1, where x is the state at T.
  - Cycles without a beat: all o_enb_*=0, o_data holds its last value.
  - Enables are never two-hot.
- Word order: first M0 word lands in the bank's upper M0 half; first K word lands in the most-significant K word.
- o_done: 1 in cycle T+1 of the final beat, coinciding with the last enable. State is IDLE in that cycle, so an i_start in T+1 is accepted (back-to-back loads; ready returns at T+2).
- o_busy: registered; 1 from the cycle after i_start through the final-beat cycle T, 0 at T+1.
- i_flush (any state, priority over all else): next cycle state IDLE, counter 0, o_enb_*=0, o_done=0. A beat accepted in the flush cycle is dropped (no enable). o_data is not cleared. The bank may hold a partial load; software reloads.
- i_start and i_flush in the same IDLE cycle: flush wins, stay IDLE.
- Upstream may deassert valid at any time; bubbles stretch the load without reordering.
- Reset mid-load: immediate return to reset values; no enable pulses after reset.

Test Plan:
- Start with kw=3, valid held high, words 0x11..0x66 → enables M0,M0,CN,K,K,K on 6 consecutive cycles starting 2 cycles after start. o_data 0x11..0x66 in order. o_done with the 0x66 enable; o_busy high for exactly 6 cycles.
- Same load with valid toggling 1,0,1,0… → same enable/data sequence with 1-cycle gaps. No enable in gap cycles; o_data holds.
- kw=0, words 0xA,0xB,0xC → M0,M0,CN only. o_done with CN enable. Never o_enb_K.
- kw=3 (max), i_flush asserted during the 2nd K beat → that beat yields no enable. IDLE next cycle, o_done never pulses. A fresh start then completes normally.
- Back-to-back: i_start in the o_done cycle → second load's first M0 enable 2 cycles later. Words not lost or duplicated.
- rst_n low during LD_CN, then release → all outputs 0. o_s_ready=0 until the next i_start. i_start while busy (re-pulsed in LD_M0) has no effect on sequence or counts.

Source files
------------

// File: rtl/conv_bank_loader.sv
// conv_bank_loader
// Sequences one layer load of the convolution parameter bank. After a start
// command it takes 32-bit words from an upstream valid/ready stream and
// forwards them in the order M0 (M0_WORDS words), CN (1 word), K (kw words).
// Each forwarded word carries a one-hot load enable for the matching bank
// register.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   i_start    load command pulse, only sampled in IDLE
//   i_k_words  kernel word count for this load, sampled with i_start
//   i_flush    synchronous abort back to IDLE, has priority over everything
//   i_s_valid  upstream word valid
//   i_s_data   upstream word
//   o_s_ready  loader accepts a word (any load state)
//   o_enb_M0   bank M0 shift enable
//   o_enb_CN   bank CN load enable
//   o_enb_K    bank K shift enable
//   o_data     word presented to the bank
//   o_busy     load in progress
//   o_done     one-cycle pulse together with the final enable
module conv_bank_loader #(
  parameter int WORD_WIDTH  = 32,
  parameter int M0_WORDS    = 2,
  parameter int K_WORDS_MAX = 3,
  parameter int KW_WIDTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [KW_WIDTH-1:0]   i_k_words,
  input  logic                  i_flush,
  input  logic                  i_s_valid,
  input  logic [WORD_WIDTH-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic                  o_enb_M0,
  output logic                  o_enb_CN,
  output logic                  o_enb_K,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done
);

  // The counter has to reach M0_WORDS-1 in LD_M0 and kw-1 in LD_K.
  localparam int M0_CW = $clog2(M0_WORDS + 1);
  localparam int CNT_W = (KW_WIDTH > M0_CW) ? KW_WIDTH : M0_CW;
  localparam logic [CNT_W-1:0] M0_LAST = CNT_W'(M0_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LD_M0 = 2'd1,
    LD_CN = 2'd2,
    LD_K  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [KW_WIDTH-1:0]     kw_reg, kw_next;
  logic [KW_WIDTH-1:0]     kw_clamp;
  logic [CNT_W-1:0]        kw_last;
  logic                    beat;
  logic                    take;
  logic                    last_beat;
  logic                    enb_m0_next, enb_cn_next, enb_k_next;
  logic                    enb_m0_reg, enb_cn_reg, enb_k_reg;
  logic                    done_reg;
  logic [WORD_WIDTH-1:0]   data_reg;

  // Ready is a pure function of state so the upstream sees it without delay.
  assign o_s_ready = (state_reg != IDLE);
  assign beat      = i_s_valid & o_s_ready;
  // A beat that coincides with a flush is dropped entirely.
  assign take      = beat & ~i_flush;

  assign kw_clamp = (int'(i_k_words) > K_WORDS_MAX) ? KW_WIDTH'(K_WORDS_MAX) : i_k_words;
  // Only used in LD_K, where kw_reg is known to be non-zero.
  assign kw_last  = CNT_W'(kw_reg) - CNT_W'(1);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    kw_next     = kw_reg;
    last_beat   = 1'b0;
    enb_m0_next = 1'b0;
    enb_cn_next = 1'b0;
    enb_k_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          kw_next    = kw_clamp;
          cnt_next   = '0;
          state_next = LD_M0;
        end
      end
      LD_M0: begin
        enb_m0_next = take;
        if (beat) begin
          if (cnt_reg == M0_LAST) begin
            cnt_next   = '0;
            state_next = LD_CN;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      LD_CN: begin
        enb_cn_next = take;
        if (beat) begin
          cnt_next = '0;
          if (kw_reg != '0) begin
            state_next = LD_K;
          end else begin
            state_next = IDLE;
            last_beat  = 1'b1;
          end
        end
      end
      LD_K: begin
        enb_k_next = take;
        if (beat) begin
          if (cnt_reg == kw_last) begin
            cnt_next   = '0;
            state_next = IDLE;
            last_beat  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (i_flush) begin
      state_next = IDLE;
      cnt_next   = '0;
      last_beat  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      kw_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      kw_reg    <= kw_next;
    end
  end

  // Bank-side outputs are registered: a beat in cycle T shows up in T+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enb_m0_reg <= 1'b0;
      enb_cn_reg <= 1'b0;
      enb_k_reg  <= 1'b0;
      done_reg   <= 1'b0;
      data_reg   <= '0;
    end else begin
      enb_m0_reg <= enb_m0_next;
      enb_cn_reg <= enb_cn_next;
      enb_k_reg  <= enb_k_next;
      done_reg   <= last_beat;
      if (take) begin
        data_reg <= i_s_data;
      end
    end
  end

  assign o_enb_M0 = enb_m0_reg;
  assign o_enb_CN = enb_cn_reg;
  assign o_enb_K  = enb_k_reg;
  assign o_data   = data_reg;
  assign o_done   = done_reg;
  // State is itself a register, so busy is registered and drops together
  // with the final enable.
  assign o_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_conv_bank_loader.sv
// Directed testbench for conv_bank_loader. Inputs change 1 ns after the rising
// edge; outputs are compared at the same point, i.e. they show the result of
// the edge just taken.
module tb_conv_bank_loader;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_k_words;
  logic        i_flush;
  logic        i_s_valid;
  logic [31:0] i_s_data;
  logic        o_s_ready;
  logic        o_enb_M0;
  logic        o_enb_CN;
  logic        o_enb_K;
  logic [31:0] o_data;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_data = 32'h0;
  bit          data_known = 1'b1;

  conv_bank_loader #(
    .WORD_WIDTH (32),
    .M0_WORDS   (2),
    .K_WORDS_MAX(3),
    .KW_WIDTH   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_k_words(i_k_words),
    .i_flush  (i_flush),
    .i_s_valid(i_s_valid),
    .i_s_data (i_s_data),
    .o_s_ready(o_s_ready),
    .o_enb_M0 (o_enb_M0),
    .o_enb_CN (o_enb_CN),
    .o_enb_K  (o_enb_K),
    .o_data   (o_data),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {enb_M0, enb_CN, enb_K, done, busy, ready, data}; data is
  // masked out when chk_d is 0.
  task automatic ex(input string tag, input bit m0, input bit cn, input bit k,
                    input bit dn, input bit bsy, input bit rdy,
                    input logic [31:0] d, input bit chk_d);
    logic [37:0] got;
    logic [37:0] exp;
    got = {o_enb_M0, o_enb_CN, o_enb_K, o_done, o_busy, o_s_ready,
           (chk_d ? o_data : 32'h0)};
    exp = {m0, cn, k, dn, bsy, rdy, (chk_d ? d : 32'h0)};
    n_checks++;
    $display("%s: enb(M0,CN,K)=%b%b%b done=%b busy=%b ready=%b data=%h",
             tag, o_enb_M0, o_enb_CN, o_enb_K, o_done, o_busy, o_s_ready, o_data);
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One load: start pulse, then 3+kw beats with word i = base + inc*i.
  // gap inserts a valid-low cycle before every beat but the first.
  // restart re-pulses i_start (with kw=0) on the first beat.
  // flush_at asserts i_flush with that beat and ends the load there.
  // stop_at leaves the task just before that beat.
  task automatic run_load(input string nm, input logic [1:0] kw,
                          input logic [31:0] base, input logic [31:0] inc,
                          input bit gap, input bit restart,
                          input int flush_at, input int stop_at);
    int n;
    logic [31:0] w;
    bit last;
    n = 3 + int'(kw);
    i_start   = 1'b1;
    i_k_words = kw;
    i_s_valid = 1'b0;
    step();
    i_start = 1'b0;
    ex($sformatf("%s start", nm), 0, 0, 0, 0, 1, 1, last_data, data_known);
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) return;
      if (gap && i > 0) begin
        i_s_valid = 1'b0;
        i_s_data  = 32'hDEAD_BEEF;
        step();
        ex($sformatf("%s gap%0d", nm, i), 0, 0, 0, 0, 1, 1, last_data, 1);
      end
      w         = base + inc * 32'(i);
      i_s_valid = 1'b1;
      i_s_data  = w;
      if (restart && i == 0) begin
        i_start   = 1'b1;
        i_k_words = 2'd0;
      end
      if (i == flush_at) begin
        i_flush = 1'b1;
        step();
        i_flush   = 1'b0;
        i_s_valid = 1'b0;
        ex($sformatf("%s flushed beat%0d", nm, i), 0, 0, 0, 0, 0, 0, 32'h0, 0);
        data_known = 1'b0;
        return;
      end
      step();
      i_start    = 1'b0;
      last       = (i == n - 1);
      last_data  = w;
      data_known = 1'b1;
      ex($sformatf("%s beat%0d", nm, i), i < 2, i == 2, i > 2, last, !last, !last, w, 1);
    end
    i_s_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_k_words = 2'd0;
    i_flush   = 1'b0;
    i_s_valid = 1'b0;
    i_s_data  = 32'h0;

    // Reset state.
    step();
    step();
    ex("reset", 0, 0, 0, 0, 0, 0, 32'h0, 1);
    rst_n = 1'b1;
    step();
    ex("idle after reset", 0, 0, 0, 0, 0, 0, 32'h0, 1);

    // kw=3, valid held high: M0,M0,CN,K,K,K with 0x11..0x66.
    run_load("t1", 2'd3, 32'h11, 32'h11, 0, 0, -1, -1);
    step();
    ex("t1 idle", 0, 0, 0, 0, 0, 0, last_data, 1);

    // Same load with valid toggling.
    run_load("t2", 2'd3, 32'h11, 32'h11, 1, 0, -1, -1);
    step();
    ex("t2 idle", 0, 0, 0, 0, 0, 0, last_data, 1);

    // kw=0: M0,M0,CN and done with CN; valid in IDLE is not accepted.
    run_load("t3", 2'd0, 32'hA, 32'h1, 0, 0, -1, -1);
    i_s_valid = 1'b1;
    i_s_data  = 32'h0BAD;
    step();
    ex("t3 idle valid", 0, 0, 0, 0, 0, 0, last_data, 1);
    i_s_valid = 1'b0;

    // Flush on the 2nd K beat, then a clean load.
    run_load("t4", 2'd3, 32'h11, 32'h11, 0, 0, 4, -1);
    step();
    ex("t4 after flush", 0, 0, 0, 0, 0, 0, 32'h0, 0);
    run_load("t4b", 2'd3, 32'hA1, 32'h1, 0, 0, -1, -1);
    step();
    ex("t4b idle", 0, 0, 0, 0, 0, 0, last_data, 1);

    // Back-to-back: second start issued in the done cycle of the first.
    run_load("t5a", 2'd1, 32'h1, 32'h1, 0, 0, -1, -1);
    run_load("t5b", 2'd2, 32'h10, 32'h1, 0, 0, -1, -1);
    step();
    ex("t5 idle", 0, 0, 0, 0, 0, 0, last_data, 1);

    // Start and flush together in IDLE: flush wins.
    i_start   = 1'b1;
    i_k_words = 2'd3;
    i_flush   = 1'b1;
    step();
    i_start = 1'b0;
    i_flush = 1'b0;
    ex("t6 start+flush", 0, 0, 0, 0, 0, 0, last_data, 1);
    step();
    ex("t6 still idle", 0, 0, 0, 0, 0, 0, last_data, 1);

    // Reset while in LD_CN.
    run_load("t7", 2'd2, 32'h21, 32'h1, 0, 0, -1, 2);
    rst_n = 1'b0;
    #2;
    ex("t7 async reset", 0, 0, 0, 0, 0, 0, 32'h0, 1);
    last_data = 32'h0;
    step();
    rst_n     = 1'b1;
    i_s_valid = 1'b1;
    i_s_data  = 32'h77;
    step();
    ex("t7 after release", 0, 0, 0, 0, 0, 0, 32'h0, 1);
    step();
    ex("t7 no ready", 0, 0, 0, 0, 0, 0, 32'h0, 1);
    i_s_valid = 1'b0;

    // i_start re-pulsed during LD_M0 must not shorten the kw=3 load.
    run_load("t8", 2'd3, 32'h51, 32'h1, 0, 1, -1, -1);
    step();
    ex("t8 idle", 0, 0, 0, 0, 0, 0, last_data, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
